// File: rtl/uart_reg_master_if.sv
// uart_reg_master_if
//   Request/response bundle between a requester and uart_reg_master.
//   Request : req_valid_in, req_ready_out, req_write_in, req_addr_in[6:0],
//             req_wdata_in[7:0]
//   Response: rsp_valid_out (one-cycle pulse), rsp_data_out[7:0],
//             rsp_timeout_out, rsp_frame_err_out (qualify rsp_valid_out)
//   Modports: slave  - the uart_reg_master side (receives requests)
//             master - the requester side
interface uart_reg_master_if;
    logic       req_valid_in;
    logic       req_ready_out;
    logic       req_write_in;
    logic [6:0] req_addr_in;
    logic [7:0] req_wdata_in;
    logic       rsp_valid_out;
    logic [7:0] rsp_data_out;
    logic       rsp_timeout_out;
    logic       rsp_frame_err_out;

    modport slave (
        input  req_valid_in, req_write_in, req_addr_in, req_wdata_in,
        output req_ready_out, rsp_valid_out, rsp_data_out,
               rsp_timeout_out, rsp_frame_err_out
    );

    modport master (
        output req_valid_in, req_write_in, req_addr_in, req_wdata_in,
        input  req_ready_out, rsp_valid_out, rsp_data_out,
               rsp_timeout_out, rsp_frame_err_out
    );
endinterface

// File: rtl/uart_reg_master.sv
// uart_reg_master
//   Host-side initiator for the UART register-bank protocol. A write sends
//   {0,addr} then data; a read sends {1,addr} and captures one reply byte.
//   Ports:
//     clk_in    - system clock
//     rst_in_n  - asynchronous active-low reset
//     bus       - request/response bundle (uart_reg_master_if.slave)
//     busy_out  - high while a transaction is in flight
//     tx_out    - UART line to the bank, idle high
//     rx_in     - UART line from the bank, asynchronous
//   GAP_BITS is expected to be >= 1 and CLKS_PER_BIT >= 4.
module uart_reg_master #(
    parameter int CLKS_PER_BIT = 142,
    parameter int GAP_BITS     = 1,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    uart_reg_master_if.slave  bus,
    output logic              busy_out,
    output logic              tx_out,
    input  logic              rx_in
);
    localparam int GAP_CYC  = GAP_BITS * CLKS_PER_BIT;
    localparam int TOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int HALF     = CLKS_PER_BIT / 2;
    localparam int CNT_MAX  = (GAP_CYC > CLKS_PER_BIT) ? GAP_CYC : CLKS_PER_BIT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int TOUT_W   = $clog2(TOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, TX_CMD, TX_GAP, TX_DATA, TX_GAP2, RX_WAIT, RX_BYTE, DONE
    } state_t;

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [TOUT_W-1:0]   r_tout;
    logic [3:0]          r_idx;
    logic                r_write;
    logic [7:0]          r_wdata;
    logic [9:0]          r_tx_sh;
    logic [7:0]          r_rx_sh;
    logic                r_rx_p0, r_rx_p1, r_rx_p2;
    logic [7:0]          r_rsp_data;
    logic                r_rsp_to, r_rsp_fe;

    logic w_accept, w_tx_state, w_bit_end, w_gap_end, w_frame_end;
    logic w_start, w_tout_end, w_rx_sample, w_false_start, w_stop, w_state_chg;

    assign w_accept      = bus.req_valid_in && (r_state == IDLE);
    assign w_tx_state    = (r_state == TX_CMD) || (r_state == TX_DATA);
    assign w_bit_end     = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_gap_end     = (r_cnt == CNT_W'(GAP_CYC - 1));
    assign w_frame_end   = w_bit_end && (r_idx == 4'd9);
    // Falling edge on the synchronized line; p2 is the previous p1 value.
    assign w_start       = r_rx_p2 && !r_rx_p1;
    assign w_tout_end    = (r_tout == TOUT_W'(TOUT_CYC - 1));
    // Start bit is checked half a bit after the edge, later bits one bit apart.
    assign w_rx_sample   = (r_idx == 4'd0) ? (r_cnt == CNT_W'(HALF - 1)) : w_bit_end;
    assign w_false_start = w_rx_sample && (r_idx == 4'd0) && r_rx_p1;
    assign w_stop        = w_rx_sample && (r_idx == 4'd9);
    assign w_state_chg   = (w_next != r_state);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) r_state <= IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_next = TX_CMD;
            TX_CMD:  if (w_frame_end) w_next = TX_GAP;
            TX_GAP:  if (w_gap_end)   w_next = r_write ? TX_DATA : RX_WAIT;
            TX_DATA: if (w_frame_end) w_next = TX_GAP2;
            TX_GAP2: if (w_gap_end)   w_next = DONE;
            RX_WAIT: begin
                if (w_start)         w_next = RX_BYTE;
                else if (w_tout_end) w_next = DONE;
            end
            RX_BYTE: begin
                if (w_false_start)   w_next = RX_WAIT;
                else if (w_stop)     w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tout     <= '0;
            r_write    <= 1'b0;
            r_rx_p0    <= 1'b1;
            r_rx_p1    <= 1'b1;
            r_rx_p2    <= 1'b1;
            r_rsp_data <= '0;
            r_rsp_to   <= 1'b0;
            r_rsp_fe   <= 1'b0;
        end else begin
            // Synchronizer (p0, p1) plus one history flop for edge detection.
            r_rx_p0 <= rx_in;
            r_rx_p1 <= r_rx_p0;
            r_rx_p2 <= r_rx_p1;

            if (w_state_chg || (w_tx_state && w_bit_end) ||
                ((r_state == RX_BYTE) && w_rx_sample))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_state_chg)
                r_idx <= '0;
            else if ((w_tx_state && w_bit_end) || ((r_state == RX_BYTE) && w_rx_sample))
                r_idx <= r_idx + 4'd1;

            // Not cleared on a false start, so glitches cannot extend the wait.
            if (w_accept)
                r_tout <= '0;
            else if (r_state == RX_WAIT)
                r_tout <= r_tout + TOUT_W'(1);

            if (w_accept)
                r_write <= bus.req_write_in;

            if (w_accept) begin
                r_rsp_to <= 1'b0;
                r_rsp_fe <= 1'b0;
            end else if (w_state_chg && (w_next == DONE)) begin
                case (r_state)
                    RX_WAIT: begin
                        r_rsp_data <= '0;
                        r_rsp_to   <= 1'b1;
                    end
                    RX_BYTE: begin
                        r_rsp_data <= r_rx_sh;
                        r_rsp_fe   <= ~r_rx_p1;
                    end
                    default: r_rsp_data <= '0;
                endcase
            end
        end
    end

    // Datapath shift registers: contents are only observed in states that load them first.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_wdata <= bus.req_wdata_in;
            r_tx_sh <= {1'b1, ~bus.req_write_in, bus.req_addr_in, 1'b0};
        end else if ((r_state == TX_GAP) && (w_next == TX_DATA)) begin
            r_tx_sh <= {1'b1, r_wdata, 1'b0};
        end else if (w_tx_state && w_bit_end) begin
            r_tx_sh <= {1'b1, r_tx_sh[9:1]};
        end

        if ((r_state == RX_BYTE) && w_rx_sample && (r_idx != 4'd0) && (r_idx != 4'd9))
            r_rx_sh <= {r_rx_p1, r_rx_sh[7:1]};
    end

    // Driven from state so reset forces the line high without waiting for a clock.
    assign tx_out                = w_tx_state ? r_tx_sh[0] : 1'b1;
    assign bus.req_ready_out     = (r_state == IDLE);
    assign busy_out              = (r_state != IDLE);
    assign bus.rsp_valid_out     = (r_state == DONE);
    assign bus.rsp_data_out      = r_rsp_data;
    assign bus.rsp_timeout_out   = r_rsp_to;
    assign bus.rsp_frame_err_out = r_rsp_fe;
endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master
//   Directed bench for uart_reg_master: checks reset values, write and read
//   framing on tx_out, read replies, timeout, frame error, glitch rejection
//   and reset abort.
module tb_uart_reg_master;
    localparam int CPB      = 142;
    localparam int GAPB     = 1;
    localparam int TOB      = 32;
    localparam int GAP_CYC  = GAPB * CPB;
    localparam int TOUT_CYC = TOB * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic busy;
    logic tx;

    uart_reg_master_if bus_if();

    uart_reg_master #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS(GAPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk_in(clk),
        .rst_in_n(rst_n),
        .bus(bus_if.slave),
        .busy_out(busy),
        .tx_out(tx),
        .rx_in(rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic       got_ok;
    int         got_cyc;
    logic [7:0] got_data;
    logic       got_to, got_fe, got_nv, got_nr;
    logic [7:0] cap;
    int         bad;

    // Issue one request; returns #1 after the accept edge.
    task automatic issue(input logic wr, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (bus_if.req_ready_out !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        bus_if.req_valid_in = 1'b1;
        bus_if.req_write_in = wr;
        bus_if.req_addr_in  = a;
        bus_if.req_wdata_in = d;
        @(posedge clk);
        #1;
        bus_if.req_valid_in = 1'b0;
    endtask

    // Follow one frame plus gap on tx_out; cap = mid-bit data, bad = cycles off expectation.
    task automatic tx_frame(input logic [7:0] exp);
        logic [9:0] f;
        f   = {1'b1, exp, 1'b0};
        bad = 0;
        cap = 8'h00;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (tx !== f[b]) bad++;
                if (k == CPB / 2 && b >= 1 && b <= 8) cap[b-1] = tx;
            end
        end
        for (int k = 0; k < GAP_CYC; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
    endtask

    // Wait (bounded) for rsp_valid_out, record response and the following cycle.
    task automatic wait_rsp(input int budget);
        got_ok = 1'b0;
        got_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid_out === 1'b1) begin
                got_ok   = 1'b1;
                got_cyc  = i;
                got_data = bus_if.rsp_data_out;
                got_to   = bus_if.rsp_timeout_out;
                got_fe   = bus_if.rsp_frame_err_out;
                break;
            end
        end
        @(negedge clk);
        got_nv = bus_if.rsp_valid_out;
        got_nr = bus_if.req_ready_out;
    endtask

    // Bank-side UART transmitter on rx_in.
    task automatic uart_reply(input logic [7:0] d, input logic stopb, input int delay);
        repeat (delay) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            repeat (CPB) @(negedge clk);
        end
        rx = stopb;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
        checks++; if (bus_if.req_ready_out !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus_if.req_ready_out); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (bus_if.rsp_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_if.rsp_valid_out); else passed++;
        checks++; if (bus_if.rsp_data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", bus_if.rsp_data_out); else passed++;
        checks++; if ({bus_if.rsp_timeout_out, bus_if.rsp_frame_err_out} !== 2'b00)
            $display("FAIL reset_flags: got %b want 00", {bus_if.rsp_timeout_out, bus_if.rsp_frame_err_out}); else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        issue(1'b1, 7'h03, 8'h5A);
        checks++; if ({bus_if.req_ready_out, busy} !== 2'b01) $display("FAIL wr_busy: got ready/busy %b want 01", {bus_if.req_ready_out, busy}); else passed++;
        tx_frame(8'h03);
        checks++; if (cap !== 8'h03) $display("FAIL wr_cmd_byte: got %h want 03", cap); else passed++;
        checks++; if (bad !== 0) $display("FAIL wr_cmd_timing: got %0d bad cycles want 0", bad); else passed++;
        tx_frame(8'h5A);
        checks++; if (cap !== 8'h5A) $display("FAIL wr_data_byte: got %h want 5a", cap); else passed++;
        checks++; if (bad !== 0) $display("FAIL wr_data_timing: got %0d bad cycles want 0", bad); else passed++;
        wait_rsp(50);
        checks++; if (got_cyc !== 0) $display("FAIL wr_rsp_time: got %0d want 0", got_cyc); else passed++;
        checks++; if ({got_to, got_fe, got_data} !== 10'h000) $display("FAIL wr_rsp: got to=%b fe=%b data=%h want 0 0 00", got_to, got_fe, got_data); else passed++;
        checks++; if ({got_nv, got_nr} !== 2'b01) $display("FAIL wr_after: got valid/ready %b want 01", {got_nv, got_nr}); else passed++;
    endtask

    task automatic test_read_ok;
        issue(1'b0, 7'h07, 8'h00);
        tx_frame(8'h87);
        checks++; if (cap !== 8'h87 || bad !== 0) $display("FAIL rd_cmd: got %h bad=%0d want 87 bad=0", cap, bad); else passed++;
        fork
            uart_reply(8'hBA, 1'b1, 30);
            wait_rsp(TOUT_CYC + 12 * CPB);
        join
        checks++; if (got_ok !== 1'b1) $display("FAIL rd_rsp_seen: got %b want 1", got_ok); else passed++;
        checks++; if (got_data !== 8'hBA) $display("FAIL rd_data: got %h want ba", got_data); else passed++;
        checks++; if ({got_to, got_fe} !== 2'b00) $display("FAIL rd_flags: got %b want 00", {got_to, got_fe}); else passed++;
        checks++; if ({got_nv, got_nr} !== 2'b01) $display("FAIL rd_after: got valid/ready %b want 01", {got_nv, got_nr}); else passed++;
    endtask

    task automatic test_timeout;
        issue(1'b0, 7'h02, 8'h00);
        tx_frame(8'h82);
        checks++; if (cap !== 8'h82 || bad !== 0) $display("FAIL to_cmd: got %h bad=%0d want 82 bad=0", cap, bad); else passed++;
        wait_rsp(TOUT_CYC + 100);
        checks++; if (got_cyc !== TOUT_CYC) $display("FAIL to_time: got %0d want %0d", got_cyc, TOUT_CYC); else passed++;
        checks++; if ({got_to, got_fe, got_data} !== 10'h200) $display("FAIL to_rsp: got to=%b fe=%b data=%h want 1 0 00", got_to, got_fe, got_data); else passed++;
    endtask

    task automatic test_frame_err;
        issue(1'b0, 7'h05, 8'h00);
        tx_frame(8'h85);
        checks++; if (cap !== 8'h85 || bad !== 0) $display("FAIL fe_cmd: got %h bad=%0d want 85 bad=0", cap, bad); else passed++;
        fork
            uart_reply(8'h3C, 1'b0, 30);
            wait_rsp(TOUT_CYC + 12 * CPB);
        join
        checks++; if (got_ok !== 1'b1) $display("FAIL fe_rsp_seen: got %b want 1", got_ok); else passed++;
        checks++; if ({got_to, got_fe, got_data} !== 10'h13C) $display("FAIL fe_rsp: got to=%b fe=%b data=%h want 0 1 3c", got_to, got_fe, got_data); else passed++;
    endtask

    task automatic test_glitch;
        issue(1'b0, 7'h04, 8'h00);
        tx_frame(8'h84);
        checks++; if (cap !== 8'h84 || bad !== 0) $display("FAIL gl_cmd: got %h bad=%0d want 84 bad=0", cap, bad); else passed++;
        fork
            begin
                repeat (10) @(negedge clk);
                rx = 1'b0;
                repeat (20) @(negedge clk);
                rx = 1'b1;
                repeat (200) @(negedge clk);
                uart_reply(8'h81, 1'b1, 0);
            end
            wait_rsp(TOUT_CYC + 12 * CPB);
        join
        checks++; if (got_ok !== 1'b1) $display("FAIL gl_rsp_seen: got %b want 1", got_ok); else passed++;
        checks++; if ({got_to, got_fe, got_data} !== 10'h081) $display("FAIL gl_rsp: got to=%b fe=%b data=%h want 0 0 81", got_to, got_fe, got_data); else passed++;
    endtask

    task automatic test_reset_abort;
        int pulses_seen = 0;
        issue(1'b1, 7'h01, 8'h00);
        // Middle of data bit 3 of command byte 0x01 (frame bit index 4), which is 0.
        repeat (4 * CPB + 70) @(negedge clk);
        checks++; if (tx !== 1'b0) $display("FAIL ab_pre_tx: got %b want 0", tx); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL ab_tx_async: got %b want 1", tx); else passed++;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.rsp_valid_out !== 1'b0) pulses_seen++;
        end
        rst_n = 1'b1;
        #1;
        checks++; if ({bus_if.req_ready_out, busy} !== 2'b10) $display("FAIL ab_ready: got ready/busy %b want 10", {bus_if.req_ready_out, busy}); else passed++;
        repeat (3000) begin
            @(negedge clk);
            if (bus_if.rsp_valid_out !== 1'b0) pulses_seen++;
        end
        checks++; if (pulses_seen !== 0) $display("FAIL ab_no_rsp: got %0d pulses want 0", pulses_seen); else passed++;
        issue(1'b1, 7'h01, 8'hFF);
        tx_frame(8'h01);
        checks++; if (cap !== 8'h01 || bad !== 0) $display("FAIL ab_cmd: got %h bad=%0d want 01 bad=0", cap, bad); else passed++;
        tx_frame(8'hFF);
        checks++; if (cap !== 8'hFF || bad !== 0) $display("FAIL ab_data: got %h bad=%0d want ff bad=0", cap, bad); else passed++;
        wait_rsp(50);
        checks++; if (got_cyc !== 0) $display("FAIL ab_rsp_time: got %0d want 0", got_cyc); else passed++;
        checks++; if ({got_to, got_fe, got_data} !== 10'h000) $display("FAIL ab_rsp: got to=%b fe=%b data=%h want 0 0 00", got_to, got_fe, got_data); else passed++;
    endtask

    initial begin
        bus_if.req_valid_in = 1'b0;
        bus_if.req_write_in = 1'b0;
        bus_if.req_addr_in  = 7'h00;
        bus_if.req_wdata_in = 8'h00;
        test_reset;
        test_write;
        test_read_ok;
        test_timeout;
        test_frame_err;
        test_glitch;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
